load_store_unit: RTL

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 302 ++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//   RV32-style load/store unit with a private word-organised memory. Accepts
//   one request at a time, spends WAIT_CYCLES+1 cycles in ACCESS, commits the
//   read or byte-lane-merged write on the last ACCESS edge, then presents a
//   one-cycle response. Illegal funct3 codes are answered with resp_err after
//   a single cycle and never touch memory.
//
//   Build option: define LSU_MISALIGN_TRAP_EN to reject misaligned halfword and
//   word accesses. Without it, the low address bits are forced to natural
//   alignment and the access proceeds.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   req_valid/req_ready        request handshake (ready only when idle)
//   req_we, req_funct3         store/load select, RV32 width/sign code
//   req_addr, req_wdata        byte address, LSB-aligned store data
//   resp_valid                 one-cycle response strobe
//   resp_rdata, resp_err       extended load data / reject flag (0 when idle)
//   wr, rd                     one-cycle commit pulses, coincident with resp
//   addr, wr_data, rd_data     last committed word index and data (held)
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 11,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              wr,
  output logic              rd,
  output logic [ADDR_W-3:0] addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] rd_data
);

  localparam int         IDX_W    = ADDR_W - 2;
  localparam int         DEPTH    = 2 ** IDX_W;
  localparam logic [3:0] WAIT_CNT = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Pick the addressed lane and sign/zero extend it.
  function automatic logic [31:0] load_extract(input logic [31:0] word,
                                               input logic [2:0]  f3,
                                               input logic [1:0]  off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (off)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      2'd3:    b = word[31:24];
      default: b = word[7:0];
    endcase
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  r = {{24{b[7]}}, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b010:  r = word;
      3'b100:  r = {24'h000000, b};
      3'b101:  r = {16'h0000, h};
      default: r = 32'h00000000;
    endcase
    return r;
  endfunction

  // Replace only the addressed byte lanes of the old word.
  function automatic logic [31:0] store_merge(input logic [31:0] old,
                                              input logic [31:0] wd,
                                              input logic [2:0]  f3,
                                              input logic [1:0]  off);
    logic [31:0] r;
    r = old;
    case (f3)
      3'b000: begin
        case (off)
          2'd0:    r[7:0]   = wd[7:0];
          2'd1:    r[15:8]  = wd[7:0];
          2'd2:    r[23:16] = wd[7:0];
          2'd3:    r[31:24] = wd[7:0];
          default: r = old;
        endcase
      end
      3'b001: begin
        if (off[1]) begin
          r[31:16] = wd[15:0];
        end else begin
          r[15:0] = wd[15:0];
        end
      end
      3'b010:  r = wd;
      default: r = old;
    endcase
    return r;
  endfunction

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [2:0]          f3_q, f3_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [1:0]          off_q, off_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                req_ready_q, req_ready_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   resp_rdata_q, resp_rdata_d;
  logic                resp_err_q, resp_err_d;
  logic                wr_q, wr_d;
  logic                rd_q, rd_d;
  logic [IDX_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   old_word_s;
  logic [DATA_W-1:0]   load_word_s;
  logic [DATA_W-1:0]   merge_word_s;
  logic                commit_s;
  logic [1:0]          off_s;
  logic                f3_ok_s;
  logic                req_ok_s;
`ifdef LSU_MISALIGN_TRAP_EN
  logic                misalign_s;
`endif

  // Request decode: aligned lane offset and legality of the incoming request.
  always_comb begin
    off_s   = req_addr[1:0];
    f3_ok_s = 1'b0;
    case (req_funct3[1:0])
      2'b00:   off_s = req_addr[1:0];
      2'b01:   off_s = {req_addr[1], 1'b0};
      2'b10:   off_s = 2'b00;
      default: off_s = req_addr[1:0];
    endcase
    if (req_we) begin
      f3_ok_s = (req_funct3 <= 3'b010);
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_ok_s = 1'b1;
        default:                                f3_ok_s = 1'b0;
      endcase
    end
`ifdef LSU_MISALIGN_TRAP_EN
    case (req_funct3[1:0])
      2'b01:   misalign_s = req_addr[0];
      2'b10:   misalign_s = (req_addr[1:0] != 2'b00);
      default: misalign_s = 1'b0;
    endcase
    req_ok_s = f3_ok_s && !misalign_s;
`else
    req_ok_s = f3_ok_s;
`endif
  end

  // Memory-side datapath for the registered request.
  always_comb begin
    old_word_s   = mem[idx_q];
    load_word_s  = load_extract(old_word_s, f3_q, off_q);
    merge_word_s = store_merge(old_word_s, wdata_q, f3_q, off_q);
    commit_s     = (state_q == ACCESS) && (cnt_q == 4'd0);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    f3_d         = f3_q;
    idx_d        = idx_q;
    off_d        = off_q;
    wdata_d      = wdata_q;
    addr_d       = addr_q;
    wr_data_d    = wr_data_q;
    rd_data_d    = rd_data_q;
    resp_valid_d = 1'b0;
    resp_rdata_d = '0;
    resp_err_d   = 1'b0;
    wr_d         = 1'b0;
    rd_d         = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          idx_d   = req_addr[ADDR_W-1:2];
          off_d   = off_s;
          wdata_d = req_wdata;
          if (req_ok_s) begin
            state_d = ACCESS;
            cnt_d   = WAIT_CNT;
          end else begin
            // Rejected requests skip ACCESS entirely.
            state_d      = RESP;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
      ACCESS: begin
        if (!commit_s) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d      = RESP;
          resp_valid_d = 1'b1;
          addr_d       = idx_q;
          if (we_q) begin
            wr_d      = 1'b1;
            wr_data_d = merge_word_s;
          end else begin
            rd_d         = 1'b1;
            rd_data_d    = load_word_s;
            resp_rdata_d = load_word_s;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
    req_ready_d = (state_d == IDLE);
  end

  // State, request and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= 4'd0;
      we_q         <= 1'b0;
      f3_q         <= 3'b000;
      idx_q        <= '0;
      off_q        <= 2'b00;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
      addr_q       <= '0;
      wr_data_q    <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      f3_q         <= f3_d;
      idx_q        <= idx_d;
      off_q        <= off_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
      wr_q         <= wr_d;
      rd_q         <= rd_d;
      addr_q       <= addr_d;
      wr_data_q    <= wr_data_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // Word memory; deliberately outside reset so contents survive it. An
  // asserted reset returns the FSM to IDLE, so no commit can follow.
  always_ff @(posedge clk) begin
    if (commit_s && we_q) begin
      mem[idx_q] <= merge_word_s;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;
  assign resp_err   = resp_err_q;
  assign wr         = wr_q;
  assign rd         = rd_q;
  assign addr       = addr_q;
  assign wr_data    = wr_data_q;
  assign rd_data    = rd_data_q;

endmodule
